// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/load-store arbiter for one fixed-latency 32-bit memory port
// Define MEM_ARB_MISALIGN_TRAP_EN to reject misaligned or reserved-size data accesses.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int MEM_LATENCY = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic [31:0]       if_rdata_out,
  output logic              if_valid_out,
  input  logic              dm_re_in,
  input  logic              dm_we_in,
  input  logic [ADDR_W-1:0] dm_addr_in,
  input  logic [1:0]        dm_size_in,
  input  logic              dm_signed_in,
  input  logic [31:0]       dm_wdata_in,
  output logic [31:0]       dm_rdata_out,
  output logic              dm_done_out,
  output logic              dm_err_out,
  output logic              stall_out,
  output logic              mem_req_out,
  output logic              mem_we_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [3:0]        mem_be_out,
  output logic [31:0]       mem_wdata_out,
  input  logic [31:0]       mem_rdata_in
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0]        LAST      = 4'(MEM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  state_t            state_q;
  logic [3:0]        cnt_q;
  logic              data_q, store_q, signed_q, err_q;
  logic [1:0]        size_q, lo_q;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q, if_rdata_q, dm_rdata_q;

  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        reject_d;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;
  logic        other_pending;

  // Grant-time lane decode; size 10 falls through to the word case.
  always_comb begin
    be_d     = 4'b1111;
    wdata_d  = dm_wdata_in;
    reject_d = 1'b0;
    case (dm_size_in)
      2'b00: begin
        be_d    = 4'b1000 >> dm_addr_in[1:0];
        wdata_d = {4{dm_wdata_in[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b1100 >> {dm_addr_in[1], 1'b0};
        wdata_d = {2{dm_wdata_in[15:0]}};
`ifdef MEM_ARB_MISALIGN_TRAP_EN
        reject_d = dm_addr_in[0];
`endif
      end
      default: begin
`ifdef MEM_ARB_MISALIGN_TRAP_EN
        reject_d = (dm_addr_in[1:0] != 2'b00) || (dm_size_in == 2'b10);
`endif
      end
    endcase
  end

  // Big-endian lane select: offset 0 is the most significant byte.
  always_comb begin
    byte_v   = mem_rdata_in[31:24];
    half_v   = lo_q[1] ? mem_rdata_in[15:0] : mem_rdata_in[31:16];
    load_ext = mem_rdata_in;
    case (lo_q)
      2'd1:    byte_v = mem_rdata_in[23:16];
      2'd2:    byte_v = mem_rdata_in[15:8];
      2'd3:    byte_v = mem_rdata_in[7:0];
      default: byte_v = mem_rdata_in[31:24];
    endcase
    if (size_q == 2'b00)
      load_ext = {{24{signed_q & byte_v[7]}}, byte_v};
    else if (size_q == 2'b01)
      load_ext = {{16{signed_q & half_v[15]}}, half_v};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      data_q     <= 1'b0;
      store_q    <= 1'b0;
      signed_q   <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 2'b00;
      lo_q       <= 2'b00;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'd0;
      if_rdata_q <= 32'd0;
      dm_rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= 4'd0;
          if (dm_re_in || dm_we_in) begin
            data_q     <= 1'b1;
            store_q    <= dm_we_in;
            signed_q   <= dm_signed_in;
            size_q     <= dm_size_in;
            lo_q       <= dm_addr_in[1:0];
            mem_addr_q <= dm_addr_in & WORD_MASK;
            be_q       <= be_d;
            wdata_q    <= dm_we_in ? wdata_d : 32'd0;
            if (reject_d) begin
              err_q   <= 1'b1;
              state_q <= RESP;
            end else begin
              err_q     <= 1'b0;
              mem_req_q <= 1'b1;
              mem_we_q  <= dm_we_in;
              state_q   <= BUSY;
            end
          end else if (if_req_in) begin
            data_q     <= 1'b0;
            store_q    <= 1'b0;
            err_q      <= 1'b0;
            mem_addr_q <= if_addr_in & WORD_MASK;
            be_q       <= 4'b1111;
            wdata_q    <= 32'd0;
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == LAST) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= RESP;
            if (!data_q)
              if_rdata_q <= mem_rdata_in;
            else if (!store_q)
              dm_rdata_q <= load_ext;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign other_pending = data_q ? if_req_in : (dm_re_in | dm_we_in);
  assign stall_out     = ~rst_in & (if_req_in | dm_re_in | dm_we_in)
                       & ~((state_q == RESP) & ~other_pending);

  assign if_valid_out  = (state_q == RESP) & ~data_q;
  assign dm_done_out   = (state_q == RESP) & data_q & ~err_q;
`ifdef MEM_ARB_MISALIGN_TRAP_EN
  assign dm_err_out    = (state_q == RESP) & data_q & err_q;
`else
  assign dm_err_out    = 1'b0;
`endif

  assign if_rdata_out  = if_rdata_q;
  assign dm_rdata_out  = dm_rdata_q;
  assign mem_req_out   = mem_req_q;
  assign mem_we_out    = mem_we_q;
  assign mem_addr_out  = mem_addr_q;
  assign mem_be_out    = be_q;
  assign mem_wdata_out = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed checks of mem_port_arbiter with MEM_LATENCY=2
module tb_mem_port_arbiter;

  logic        clk = 1'b0, rst = 1'b1;
  logic        if_req = 1'b0, if_valid;
  logic [31:0] if_addr = '0, if_rdata;
  logic        dm_re = 1'b0, dm_we = 1'b0, dm_signed = 1'b0;
  logic [31:0] dm_addr = '0, dm_wdata = '0, dm_rdata;
  logic [1:0]  dm_size = 2'b11;
  logic        dm_done, dm_err, stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]  mem_be;

  int total = 0, bad = 0;
  int lat, nstrobe, first_strobe, extra, stall1;
  logic [3:0]  c_be;
  logic        c_we, p_err;
  logic [31:0] c_addr, c_wdata;
  logic [31:0] last_load;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .MEM_LATENCY(2)) dut (
    .clk_in(clk), .rst_in(rst),
    .if_req_in(if_req), .if_addr_in(if_addr), .if_rdata_out(if_rdata), .if_valid_out(if_valid),
    .dm_re_in(dm_re), .dm_we_in(dm_we), .dm_addr_in(dm_addr), .dm_size_in(dm_size),
    .dm_signed_in(dm_signed), .dm_wdata_in(dm_wdata), .dm_rdata_out(dm_rdata),
    .dm_done_out(dm_done), .dm_err_out(dm_err), .stall_out(stall),
    .mem_req_out(mem_req), .mem_we_out(mem_we), .mem_addr_out(mem_addr),
    .mem_be_out(mem_be), .mem_wdata_out(mem_wdata), .mem_rdata_in(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Issues one request at a negedge and records what the port does until the pulse.
  task automatic access(input bit fetch, input bit re, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input bit sgn, input logic [31:0] wd,
                        input logic [31:0] rd);
    bit done;
    if_req = fetch; if_addr = addr;
    dm_re = re; dm_we = we; dm_addr = addr; dm_size = size; dm_signed = sgn; dm_wdata = wd;
    mem_rdata = rd;
    lat = -1; nstrobe = 0; first_strobe = -1; extra = 0; stall1 = -1; p_err = 1'b0;
    c_be = '0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 1) stall1 = int'(stall);
      if (mem_req) begin
        nstrobe++;
        if (first_strobe < 0) first_strobe = n;
        c_be = mem_be; c_we = mem_we; c_addr = mem_addr; c_wdata = mem_wdata;
      end
      done = fetch ? if_valid : (dm_done | dm_err);
      if (done) begin
        lat = n; p_err = dm_err;
        break;
      end
    end
    if_req = 1'b0; dm_re = 1'b0; dm_we = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (if_valid || dm_done || dm_err) extra++;
      if (mem_req) nstrobe++;
    end
  endtask

  int t_done, t_valid;
  logic s_at_done, s_at_valid, we_first, we_fetch;
  logic [31:0] a_fetch;

  initial begin
    // reset state, with a fetch request already asserted
    if_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_stall", stall, 0);
    check_eq("rst_pulses", {if_valid, dm_done, dm_err}, 0);
    check_eq("rst_rdata", if_rdata | dm_rdata | mem_addr, 0);
    if_req = 1'b0;
    rst = 1'b0;
    @(posedge clk); @(negedge clk);

    access(1, 0, 0, 32'h100, 2'b11, 0, 32'h0, 32'hDEADBEEF);
    check_eq("fetch_lat", lat, 3);
    check_eq("fetch_first_strobe", first_strobe, 1);
    check_eq("fetch_nstrobe", nstrobe, 2);
    check_eq("fetch_addr", c_addr, 32'h100);
    check_eq("fetch_be", c_be, 4'hF);
    check_eq("fetch_we", c_we, 0);
    check_eq("fetch_stall", stall1, 1);
    check_eq("fetch_rdata", if_rdata, 32'hDEADBEEF);
    check_eq("fetch_extra", extra, 0);

    access(0, 0, 1, 32'h203, 2'b00, 0, 32'h000000AB, 32'h0);
    check_eq("sb_lat", lat, 3);
    check_eq("sb_be", c_be, 4'b0001);
    check_eq("sb_wdata", c_wdata, 32'hABABABAB);
    check_eq("sb_we", c_we, 1);
    check_eq("sb_addr", c_addr, 32'h200);
    check_eq("sb_once", extra, 0);

    access(0, 0, 1, 32'h202, 2'b01, 0, 32'h12345678, 32'h0);
    check_eq("sh_be", c_be, 4'b0011);
    check_eq("sh_wdata", c_wdata, 32'h56785678);

    access(0, 1, 0, 32'h402, 2'b01, 1, 32'h0, 32'h1234F00D);
    check_eq("lh_s_be", c_be, 4'b0011);
    check_eq("lh_s_we", c_we, 0);
    check_eq("lh_s_rdata", dm_rdata, 32'hFFFFF00D);
    access(0, 1, 0, 32'h402, 2'b01, 0, 32'h0, 32'h1234F00D);
    check_eq("lh_u_rdata", dm_rdata, 32'h0000F00D);
    access(0, 1, 0, 32'h401, 2'b00, 0, 32'h0, 32'h1234F00D);
    check_eq("lbu_be", c_be, 4'b0100);
    check_eq("lbu_rdata", dm_rdata, 32'h00000034);
    access(0, 1, 0, 32'h402, 2'b00, 1, 32'h0, 32'h1234F00D);
    check_eq("lb_s_rdata", dm_rdata, 32'hFFFFFFF0);
    last_load = 32'hFFFFFFF0;

    access(0, 1, 0, 32'h101, 2'b11, 0, 32'h0, 32'hCAFEF00D);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    check_eq("lw_mis_lat", lat, 1);
    check_eq("lw_mis_err", p_err, 1);
    check_eq("lw_mis_nstrobe", nstrobe, 0);
    check_eq("lw_mis_rdata", dm_rdata, last_load);
`else
    check_eq("lw_mis_lat", lat, 3);
    check_eq("lw_mis_err", p_err, 0);
    check_eq("lw_mis_addr", c_addr, 32'h100);
    check_eq("lw_mis_be", c_be, 4'hF);
    check_eq("lw_mis_rdata", dm_rdata, 32'hCAFEF00D);
    last_load = 32'hCAFEF00D;
`endif

    access(0, 1, 0, 32'h500, 2'b10, 1, 32'h0, 32'h87654321);
`ifdef MEM_ARB_MISALIGN_TRAP_EN
    check_eq("sz10_err", p_err, 1);
    check_eq("sz10_nstrobe", nstrobe, 0);
    check_eq("sz10_rdata", dm_rdata, last_load);
`else
    check_eq("sz10_be", c_be, 4'hF);
    check_eq("sz10_rdata", dm_rdata, 32'h87654321);
`endif

    // simultaneous fetch and store: store first, fetch in the following IDLE
    if_req = 1'b1; if_addr = 32'h340;
    dm_we = 1'b1; dm_addr = 32'h300; dm_size = 2'b11; dm_wdata = 32'h11223344;
    mem_rdata = 32'h0BADF00D;
    t_done = -1; t_valid = -1; s_at_done = 1'b0; s_at_valid = 1'b1;
    we_first = 1'b0; we_fetch = 1'b1; a_fetch = '0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); @(negedge clk);
      if (n == 1) we_first = mem_we;
      if (n == 5) begin we_fetch = mem_we; a_fetch = mem_addr; end
      if (dm_done) begin t_done = n; s_at_done = stall; dm_we = 1'b0; end
      if (if_valid) begin t_valid = n; s_at_valid = stall; if_req = 1'b0; break; end
    end
    check_eq("both_done_t", t_done, 3);
    check_eq("both_stall_at_done", s_at_done, 1);
    check_eq("both_we_store", we_first, 1);
    check_eq("both_valid_t", t_valid, 7);
    check_eq("both_stall_at_valid", s_at_valid, 0);
    check_eq("both_we_fetch", we_fetch, 0);
    check_eq("both_fetch_addr", a_fetch, 32'h340);
    check_eq("both_fetch_rdata", if_rdata, 32'h0BADF00D);
    @(posedge clk); @(negedge clk);

    // reset in the middle of a store
    dm_we = 1'b1; dm_addr = 32'h600; dm_size = 2'b11; dm_wdata = 32'h55AA55AA;
    @(posedge clk); @(negedge clk);
    check_eq("midrst_pre_req", {mem_req, mem_we}, 2'b11);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_req", mem_req, 0);
    check_eq("midrst_we", mem_we, 0);
    dm_we = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("midrst_pulse", {if_valid, dm_done, dm_err}, 0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("midrst_idle", {mem_req, if_valid, dm_done, dm_err}, 0);
    access(1, 0, 0, 32'h104, 2'b11, 0, 32'h13579BDF, 32'h2468ACE0);
    check_eq("post_rst_lat", lat, 3);
    check_eq("post_rst_rdata", if_rdata, 32'h2468ACE0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
